front_panel_debounce: RTL and testbench

//  Conditions the four raw front-panel switch pins (RESET, CLEAR, RUN, HALT) before they reach the CPU.

---
 rtl/front_panel_debounce.sv | 118 +++++++++++
 tb/tb_front_panel_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : front_panel_debounce
//  Description : Synchronises, debounces and edge-detects the four raw
//                front-panel switches (RESET, CLEAR, RUN, HALT). Produces
//                one-cycle press pulses, a stretched reset pulse, the
//                debounced levels and a busy indication.
//                Optional build macro FP_INTERLOCK_EN: when defined, a RUN
//                press is dropped while HALT is high or accepting.
//  Revision    : 1.0  initial release
// ============================================================================
module front_panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int RESET_STRETCH   = 16
) (
    input  logic       SYSCLK,
    input  logic       RESET,
    input  logic       pin_RESET,
    input  logic       pin_CLEAR,
    input  logic       pin_RUN,
    input  logic       pin_HALT,
    output logic       sw_RESET,
    output logic       sw_CLEAR,
    output logic       sw_RUN,
    output logic       sw_HALT,
    output logic [3:0] sw_level,
    output logic       busy
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                 c_STR_W    = $clog2(RESET_STRETCH + 1);
    localparam logic [c_STR_W-1:0] c_STR_LOAD = c_STR_W'(RESET_STRETCH);

    // Channel order everywhere: {HALT, RUN, CLEAR, RESET}
    logic [3:0]         w_pin;
    logic [3:0]         w_stable;
    logic [3:0]         w_rise;
    logic [3:0]         w_busy_ch;
    logic               w_run_evt;
    logic [2:0]         r_pulse;    // {HALT, RUN, CLEAR}
    logic [c_STR_W-1:0] r_stretch;

    assign w_pin = {pin_HALT, pin_RUN, pin_CLEAR, pin_RESET};

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        logic               r_s1;
        logic               r_s2;
        logic               r_stable;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_differ;
        logic               w_accept;

        assign w_differ = r_s2 ^ r_stable;
        assign w_accept = w_differ && (r_cnt == c_CNT_LAST);

        // Two-flop synchroniser followed by a restart-on-agreement debounce counter
        always_ff @(posedge SYSCLK) begin
            if (RESET) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_s1 <= w_pin[gi];
                r_s2 <= r_s1;
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_stable <= r_s2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_stable[gi]  = r_stable;
        assign w_rise[gi]    = w_accept & r_s2;
        assign w_busy_ch[gi] = |r_cnt;
    end

`ifdef FP_INTERLOCK_EN
    // HALT dominates: a RUN press is discarded while HALT is high or rising
    assign w_run_evt = w_rise[2] & ~w_stable[3] & ~w_rise[3];
`else
    assign w_run_evt = w_rise[2];
`endif

    // Register press pulses so they line up with the debounced level rise
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= {w_rise[3], w_run_evt, w_rise[1]};
        end
    end

    // Reset stretch counter: load on accepted RESET press, count down to zero
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_stretch <= '0;
        end else if (w_rise[0]) begin
            r_stretch <= c_STR_LOAD;
        end else if (r_stretch != '0) begin
            r_stretch <= r_stretch - 1'b1;
        end
    end

    assign sw_RESET = (r_stretch != '0);
    assign sw_CLEAR = r_pulse[0];
    assign sw_RUN   = r_pulse[1];
    assign sw_HALT  = r_pulse[2];
    assign sw_level = w_stable;
    assign busy     = (|w_busy_ch) | (r_stretch != '0);

endmodule
`default_nettype wire

// File: tb/tb_front_panel_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_front_panel_debounce
//  Description : Self-checking bench for front_panel_debounce with
//                DEBOUNCE_CYCLES=4, RESET_STRETCH=3. Directed front-panel
//                scenarios followed by random pin activity, all compared
//                every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_front_panel_debounce;

    localparam int DB = 4;
    localparam int RS = 3;

    logic       SYSCLK = 1'b0;
    logic       r_rst  = 1'b1;
    logic [3:0] r_pins = 4'b0;   // {HALT, RUN, CLEAR, RESET}

    logic       sw_RESET, sw_CLEAR, sw_RUN, sw_HALT, busy;
    logic [3:0] sw_level;

    front_panel_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .RESET_STRETCH  (RS)
    ) u_dut (
        .SYSCLK   (SYSCLK),
        .RESET    (r_rst),
        .pin_RESET(r_pins[0]),
        .pin_CLEAR(r_pins[1]),
        .pin_RUN  (r_pins[2]),
        .pin_HALT (r_pins[3]),
        .sw_RESET (sw_RESET),
        .sw_CLEAR (sw_CLEAR),
        .sw_RUN   (sw_RUN),
        .sw_HALT  (sw_HALT),
        .sw_level (sw_level),
        .busy     (busy)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed event tallies: [0]=sw_RESET high cycles, [1..3]=CLEAR/RUN/HALT pulses
    int n_evt[4];

    // Behavioural model state
    logic [3:0] m_seen1;   // pins sampled one edge ago
    logic [3:0] m_seen2;   // pins sampled two edges ago (what the debouncer sees)
    logic [3:0] m_lvl;
    int         m_run[4];  // consecutive edges the synced pin has disagreed
    int         m_str;
    logic [3:0] m_pulse;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] pins, input logic rst);
        logic [3:0] rise;
        logic [3:0] old_lvl;
        bit         any_run;
        if (rst) begin
            m_seen1 = '0;
            m_seen2 = '0;
            m_lvl   = '0;
            m_str   = 0;
            m_pulse = '0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
            return;
        end
        rise    = '0;
        old_lvl = m_lvl;
        for (int c = 0; c < 4; c++) begin
            if (m_seen2[c] == old_lvl[c]) begin
                m_run[c] = 0;
            end else begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == DB) begin
                    m_run[c] = 0;
                    m_lvl[c] = m_seen2[c];
                    rise[c]  = m_seen2[c];
                end
            end
        end
        m_pulse = rise;
        m_pulse[0] = 1'b0;
`ifdef FP_INTERLOCK_EN
        if (old_lvl[3] || rise[3]) m_pulse[2] = 1'b0;
`endif
        if (rise[0])        m_str = RS;
        else if (m_str > 0) m_str = m_str - 1;
        m_seen2 = m_seen1;
        m_seen1 = pins;
        any_run = 0;
        for (int c = 0; c < 4; c++) if (m_run[c] > 0) any_run = 1;
        m_pulse[0] = 1'b0;
    endtask

    task automatic tick(input logic [3:0] pins, input logic rst);
        bit exp_busy;
        r_pins = pins;
        r_rst  = rst;
        @(posedge SYSCLK);
        model_step(pins, rst);
        #1;
        exp_busy = (m_str > 0);
        for (int c = 0; c < 4; c++) if (m_run[c] > 0) exp_busy = 1;
        check_val("sw_level", 32'(sw_level), 32'(m_lvl));
        check_val("sw_RESET", 32'(sw_RESET), 32'(m_str > 0));
        check_val("sw_CLEAR", 32'(sw_CLEAR), 32'(m_pulse[1]));
        check_val("sw_RUN",   32'(sw_RUN),   32'(m_pulse[2]));
        check_val("sw_HALT",  32'(sw_HALT),  32'(m_pulse[3]));
        check_val("busy",     32'(busy),     32'(exp_busy));
        if (sw_RESET) n_evt[0]++;
        if (sw_CLEAR) n_evt[1]++;
        if (sw_RUN)   n_evt[2]++;
        if (sw_HALT)  n_evt[3]++;
    endtask

    task automatic hold(input logic [3:0] pins, input int n);
        for (int k = 0; k < n; k++) tick(pins, 1'b0);
    endtask

    task automatic clear_evt();
        for (int c = 0; c < 4; c++) n_evt[c] = 0;
    endtask

    initial begin
        m_seen1 = '0; m_seen2 = '0; m_lvl = '0; m_str = 0; m_pulse = '0;
        for (int c = 0; c < 4; c++) m_run[c] = 0;
        clear_evt();

        // Reset state, including pins active during reset
        tick(4'b1111, 1'b1);
        tick(4'b0000, 1'b1);
        hold(4'b0000, 4);

        // RUN held then released: one pulse, level follows
        clear_evt();
        hold(4'b0100, 20);
        hold(4'b0000, 10);
        check_val("run_pulses", 32'(n_evt[2]), 32'd1);

        // CLEAR bouncing every 2 cycles, then held: exactly one pulse
        clear_evt();
        for (int k = 0; k < 3; k++) begin
            hold(4'b0010, 2);
            hold(4'b0000, 2);
        end
        check_val("clear_bounce_pulses", 32'(n_evt[1]), 32'd0);
        hold(4'b0010, 12);
        hold(4'b0000, 10);
        check_val("clear_pulses", 32'(n_evt[1]), 32'd1);

        // Short HALT glitch: no event, level stays low
        clear_evt();
        hold(4'b1000, 3);
        hold(4'b0000, 10);
        check_val("halt_glitch_pulses", 32'(n_evt[3]), 32'd0);
        check_val("halt_glitch_level", 32'(sw_level[3]), 32'd0);

        // RESET held: stretched pulse of RS cycles, then low while held
        clear_evt();
        hold(4'b0001, 16);
        check_val("reset_stretch_len", 32'(n_evt[0]), 32'(RS));
        hold(4'b0000, 10);

        // HALT debounced high, then RUN pressed
        clear_evt();
        hold(4'b1000, 10);
        hold(4'b1100, 10);
        hold(4'b0000, 10);
`ifdef FP_INTERLOCK_EN
        check_val("run_under_halt", 32'(n_evt[2]), 32'd0);
`else
        check_val("run_under_halt", 32'(n_evt[2]), 32'd1);
`endif

        // RUN and HALT rising together
        clear_evt();
        hold(4'b1100, 10);
        hold(4'b0000, 10);
        check_val("together_halt", 32'(n_evt[3]), 32'd1);
`ifdef FP_INTERLOCK_EN
        check_val("together_run", 32'(n_evt[2]), 32'd0);
`else
        check_val("together_run", 32'(n_evt[2]), 32'd1);
`endif

        // Block reset in mid-debounce, pin held throughout
        clear_evt();
        hold(4'b0100, 4);
        tick(4'b0100, 1'b1);
        check_val("mid_reset_level", 32'(sw_level), 32'd0);
        hold(4'b0100, 12);
        check_val("mid_reset_pulses", 32'(n_evt[2]), 32'd1);
        hold(4'b0000, 10);

        // Random pin activity with occasional block resets
        for (int s = 0; s < 1500; s++) begin
            logic [3:0] p;
            int         len;
            p   = 4'($urandom_range(0, 15));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                              : int'($urandom_range(1, 5));
            if ($urandom_range(0, 60) == 0) tick(p, 1'b1);
            hold(p, len);
        end
        hold(4'b0000, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
